// File: rtl/vec_reader_pkg.sv
// Shared types and defaults for the vector stream reader.
// Holds the burst FSM state encoding and the default output-buffer depth.
// Imported by the top and the output FIFO.
package vec_reader_pkg;

  typedef enum logic [1:0] {
    VRD_IDLE  = 2'd0,
    VRD_RUN   = 2'd1,
    VRD_DRAIN = 2'd2,
    VRD_DONE  = 2'd3
  } vrd_state_e;

  localparam int unsigned VRD_FIFO_DEPTH = 4;

endpackage

// File: rtl/vec_sync_fifo.sv
// Synchronous FIFO used as the reader's output buffer.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: pushes when full and pops when empty are ignored; head reads 0 when empty.
module vec_sync_fifo
  import vec_reader_pkg::*;
#(
  parameter int WIDTH = 33,
  parameter int DEPTH = VRD_FIFO_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           pop_data_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push_i && (count_q != CW'(DEPTH));
  assign pop_ok  = pop_i && (count_q != '0);

  // Pointer and occupancy tracking; pointers wrap naturally (power-of-two depth).
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array; contents need no reset because the head is masked when empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign pop_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/vec_stream_reader.sv
// Streams a burst of len words from a 1-cycle-latency bROM, starting at base_addr, to a valid/ready port.
// Latency: first read issued the cycle after start; one word per cycle sustained while m_ready is high.
// Backpressure: reads are throttled so FIFO occupancy plus the in-flight read never exceeds FIFO_DEPTH.
// Optional: define VEC_STREAM_READER_PERF_EN to add the stall_cnt output (blocked RUN cycles).
`ifndef CFG_IMG_VEC_NUM
`define CFG_IMG_VEC_NUM 64
`endif
`ifndef CFG_VEC_WIDTH
`define CFG_VEC_WIDTH 32
`endif

module vec_stream_reader
  import vec_reader_pkg::*;
#(
  parameter int ROM_DEPTH  = `CFG_IMG_VEC_NUM,
  parameter int DATA_WIDTH = `CFG_VEC_WIDTH,
  parameter int ADDR_WIDTH = $clog2(ROM_DEPTH),
  parameter int FIFO_DEPTH = VRD_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   len,
  output logic                  busy,
  output logic                  done,
  output logic                  arvalid,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic                  rready,
  input  logic                  rvalid,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last
`ifdef VEC_STREAM_READER_PERF_EN
  ,
  output logic [31:0]           stall_cnt
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  vrd_state_e            state_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  arvalid_q;
  logic                  inflight_q;
  logic [ADDR_WIDTH-1:0] araddr_q;
  logic [ADDR_WIDTH:0]   rd_left_q;
  logic [ADDR_WIDTH:0]   rx_left_q;

  logic [CW-1:0]         fifo_count;
  logic                  fifo_empty;
  logic [DATA_WIDTH:0]   fifo_head;

  logic                  issue;
  logic                  last_issue;
  logic                  push;
  logic                  pop;
  logic                  start_ok;
  logic                  run_d;
  logic [CW:0]           occ_d;
  logic                  arvalid_d;
  logic [ADDR_WIDTH-1:0] araddr_inc;

  // Next-cycle read permission: arvalid is registered, so it is decided from the
  // occupancy (FIFO count + in-flight read) that the next cycle will see.
  always_comb begin
    issue      = arvalid_q;
    last_issue = issue && (rd_left_q == (ADDR_WIDTH+1)'(1));
    push       = rvalid && ((state_q == VRD_RUN) || (state_q == VRD_DRAIN));
    pop        = !fifo_empty && m_ready;
    start_ok   = (state_q == VRD_IDLE) && start;
    run_d      = (start_ok && (len != '0)) || ((state_q == VRD_RUN) && !last_issue);
    occ_d      = (CW+1)'(fifo_count) + (CW+1)'(push) - (CW+1)'(pop) + (CW+1)'(issue);
    arvalid_d  = run_d && (occ_d < (CW+1)'(FIFO_DEPTH));
    araddr_inc = (araddr_q == ADDR_WIDTH'(ROM_DEPTH - 1)) ? '0 : araddr_q + 1'b1;
  end

  // Burst FSM with registered handshake and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= VRD_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      arvalid_q  <= 1'b0;
      inflight_q <= 1'b0;
      araddr_q   <= '0;
      rd_left_q  <= '0;
      rx_left_q  <= '0;
    end else begin
      arvalid_q  <= arvalid_d;
      inflight_q <= issue;
      done_q     <= 1'b0;
      if (push) rx_left_q <= rx_left_q - 1'b1;
      case (state_q)
        VRD_IDLE: begin
          if (start) begin
            araddr_q  <= base_addr;
            rd_left_q <= len;
            rx_left_q <= len;
            busy_q    <= 1'b1;
            if (len == '0) begin
              state_q <= VRD_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= VRD_RUN;
            end
          end
        end
        VRD_RUN: begin
          if (issue) begin
            araddr_q  <= araddr_inc;
            rd_left_q <= rd_left_q - 1'b1;
            if (last_issue) state_q <= VRD_DRAIN;
          end
        end
        VRD_DRAIN: begin
          // No in-flight read means no push can arrive, so empty here is final.
          if (fifo_empty && !inflight_q) begin
            state_q <= VRD_DONE;
            done_q  <= 1'b1;
          end
        end
        VRD_DONE: begin
          state_q <= VRD_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= VRD_IDLE;
      endcase
    end
  end

  vec_sync_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i ({(rx_left_q == (ADDR_WIDTH+1)'(1)), rdata}),
    .pop_i       (pop),
    .pop_data_o  (fifo_head),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  assign busy    = busy_q;
  assign done    = done_q;
  assign arvalid = arvalid_q;
  assign rready  = arvalid_q;
  assign araddr  = araddr_q;
  assign m_valid = !fifo_empty;
  assign m_data  = fifo_head[DATA_WIDTH-1:0];
  assign m_last  = fifo_head[DATA_WIDTH];

`ifdef VEC_STREAM_READER_PERF_EN
  logic [31:0] stall_cnt_q;

  // Count RUN cycles where the read was held back by buffer occupancy; saturating.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (start_ok) begin
      stall_cnt_q <= '0;
    end else if ((state_q == VRD_RUN) && !arvalid_q && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_vec_stream_reader.sv
// Bench for vec_stream_reader: bROM model, observation monitor, and directed plus
// randomized bursts compared against addresses/data derived from base, len and ROM contents.
module tb_vec_stream_reader;

  localparam int RD = 16;
  localparam int AW = 4;
  localparam int DW = 32;
  localparam int FD = 4;
  localparam int TMO = 500;

  logic          clk = 1'b0;
  logic          rst, start, rvalid, m_ready;
  logic [AW-1:0] base_addr;
  logic [AW:0]   len;
  logic [DW-1:0] rdata;
  logic          busy, done, arvalid, rready, m_valid, m_last;
  logic [AW-1:0] araddr;
  logic [DW-1:0] m_data;
`ifdef VEC_STREAM_READER_PERF_EN
  logic [31:0]   stall_cnt;
`endif

  always #5 clk = ~clk;

  vec_stream_reader #(
    .ROM_DEPTH  (RD),
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .arvalid   (arvalid),
    .araddr    (araddr),
    .rready    (rready),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last)
`ifdef VEC_STREAM_READER_PERF_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  // bROM model: one-cycle read latency
  logic [DW-1:0] rom [RD];
  initial rvalid = 1'b0;
  always @(posedge clk) begin
    rvalid <= arvalid && rready;
    rdata  <= rom[araddr];
  end

  // Monitor
  int            issued_addr[$];
  int            issued_cyc[$];
  logic [DW:0]   beats[$];
  int            done_cnt, hold_err, pair_err, stalled_issues, stall_ref, cur_len, cyc_cnt;
  logic          pv = 1'b0, pr = 1'b0, prst = 1'b1;
  logic [DW:0]   pd = '0;

  always @(negedge clk) begin
    cyc_cnt++;
    if (!rst) begin
      if (arvalid !== rready) pair_err++;
      if (arvalid && rready) begin
        issued_addr.push_back(int'(araddr));
        issued_cyc.push_back(cyc_cnt);
        if (!m_ready) stalled_issues++;
      end
      if (busy && issued_addr.size() < cur_len && !arvalid) stall_ref++;
      if (m_valid && m_ready) beats.push_back({m_last, m_data});
      if (done) done_cnt++;
      if (!prst && pv && !pr && (!m_valid || ({m_last, m_data} !== pd))) hold_err++;
    end
    pv   = m_valid;
    pr   = m_ready;
    pd   = {m_last, m_data};
    prst = rst;
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},    64'(busy),    64'd0);
    check({tag, "_done"},    64'(done),    64'd0);
    check({tag, "_arvalid"}, 64'(arvalid), 64'd0);
    check({tag, "_rready"},  64'(rready),  64'd0);
    check({tag, "_araddr"},  64'(araddr),  64'd0);
    check({tag, "_m_valid"}, 64'(m_valid), 64'd0);
    check({tag, "_m_last"},  64'(m_last),  64'd0);
    check({tag, "_m_data"},  64'(m_data),  64'd0);
  endtask

  task automatic clear_mon(input int n);
    issued_addr.delete();
    issued_cyc.delete();
    beats.delete();
    done_cnt = 0;
    hold_err = 0;
    pair_err = 0;
    stalled_issues = 0;
    stall_ref = 0;
    cur_len = n;
  endtask

  // mode 0: m_ready high; 1: random m_ready; 2: m_ready low for 10 cycles then high
  task automatic run_burst(input int base, input int n, input int mode, input string tag);
    int cyc;
    int a;
    logic [DW:0] exp_beat;
    clear_mon(n);
    base_addr = AW'(base);
    len       = (AW+1)'(n);
    start     = 1'b1;
    m_ready   = (mode != 2);
    @(posedge clk); #1;
    start     = 1'b0;
    base_addr = AW'($urandom);
    len       = (AW+1)'($urandom);
`ifdef VEC_STREAM_READER_PERF_EN
    check({tag, "_stall_cleared"}, 64'(stall_cnt), 64'd0);
`endif
    cyc = 1;
    while (done_cnt == 0 && cyc < TMO) begin
      case (mode)
        0:       m_ready = 1'b1;
        1:       m_ready = 1'($urandom_range(0, 1));
        default: m_ready = (cyc >= 10);
      endcase
      start = (cyc == 2);
      @(posedge clk); #1;
      cyc++;
    end
    start   = 1'b0;
    m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_done_seen"}, 64'(cyc < TMO), 64'd1);
    check({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
    check({tag, "_idle_busy"}, 64'(busy), 64'd0);
    check({tag, "_n_reads"}, 64'(issued_addr.size()), 64'(n));
    check({tag, "_n_beats"}, 64'(beats.size()), 64'(n));
    check({tag, "_hold"}, 64'(hold_err), 64'd0);
    check({tag, "_ar_r_pair"}, 64'(pair_err), 64'd0);
    for (int i = 0; i < n; i++) begin
      a = (base + i) % RD;
      if (i < issued_addr.size()) begin
        check($sformatf("%s_araddr%0d", tag, i), 64'(issued_addr[i]), 64'(a));
        if (mode == 0)
          check($sformatf("%s_issue_cyc%0d", tag, i), 64'(issued_cyc[i]), 64'(issued_cyc[0] + i));
      end
      if (i < beats.size()) begin
        exp_beat = {(i == n - 1), rom[a]};
        check($sformatf("%s_beat%0d", tag, i), 64'(beats[i]), 64'(exp_beat));
      end
    end
    if (mode == 2) check({tag, "_stalled_reads"}, 64'(stalled_issues), 64'(FD));
`ifdef VEC_STREAM_READER_PERF_EN
    check({tag, "_stall_cnt"}, 64'(stall_cnt), 64'(stall_ref));
    if (mode == 2) check({tag, "_stall_nonzero"}, 64'(stall_ref > 0), 64'd1);
`endif
  endtask

  initial begin
    int cyc;
    for (int i = 0; i < RD; i++) rom[i] = $urandom;
    rst = 1'b1; start = 1'b0; base_addr = '0; len = '0; m_ready = 1'b0;
    cur_len = 0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    run_burst(0, 4, 0, "base0");
    run_burst(RD - 2, 4, 0, "wrap");
    run_burst(0, 8, 2, "stall");

    // Zero-length burst: straight to a single DONE cycle, no reads
    clear_mon(0);
    base_addr = 3; len = 0; start = 1'b1;
    check("len0_busy_before", 64'(busy), 64'd0);
    @(posedge clk); #1;
    start = 1'b0;
    check("len0_done", 64'(done), 64'd1);
    check("len0_busy_in_done", 64'(busy), 64'd1);
    check("len0_arvalid", 64'(arvalid), 64'd0);
    @(posedge clk); #1;
    check("len0_done_off", 64'(done), 64'd0);
    check("len0_busy_off", 64'(busy), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("len0_no_reads", 64'(issued_addr.size()), 64'd0);
    check("len0_done_pulses", 64'(done_cnt), 64'd1);

    // Reset in the middle of a burst after two beats
    clear_mon(8);
    base_addr = 0; len = 8; start = 1'b1; m_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (beats.size() < 2 && cyc < TMO) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("midrst_two_beats", 64'(beats.size() >= 2), 64'd1);
    check("midrst_still_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("midrst");
    rst = 1'b0;
    done_cnt = 0;
    repeat (5) @(posedge clk);
    #1;
    check("midrst_no_done", 64'(done_cnt), 64'd0);
    check("midrst_stale_dropped", 64'(m_valid), 64'd0);
    check("midrst_idle", 64'(busy), 64'd0);
    run_burst(5, 2, 0, "post_rst");

    for (int k = 0; k < 6; k++)
      run_burst(int'($urandom_range(0, RD - 1)), int'($urandom_range(1, RD)), 1,
                $sformatf("rnd%0d", k));
    run_burst(7, RD, 0, "full");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
